// File: rtl/tile_spawner_pkg.sv
// Shared definitions for the tile spawner: FSM states, LFSR constants
// and the Galois step function.
package tile_spawner_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [7:0]  THRESH_DEF = 8'd230;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/tile_spawner_lfsr16.sv
// 16-bit Galois LFSR with seed load (zero seed replaced by the default).
module lfsr16
  import tile_spawner_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ld,
  input  logic [15:0] i_seed,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= LFSR_SEED;
    else if (i_ld)
      r_state <= (i_seed == '0) ? LFSR_SEED : i_seed;
    else if (i_en)
      r_state <= lfsr_next(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/tile_spawner.sv
// Spawns a 1 or 2 tile into the first empty cell found by a circular scan
// from an LFSR-chosen start index; reports full when no cell is empty.
module tile_spawner
  import tile_spawner_pkg::*;
#(
  parameter  int          ROWS   = 4,
  parameter  int          COLS   = 4,
  parameter  int          CELL_W = 4,
  parameter  logic [7:0]  THRESH = THRESH_DEF,
  localparam int          N      = ROWS * COLS,
  localparam int          IDX_W  = $clog2(N),
  localparam int          BW     = N * CELL_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          seed_ld,
  input  logic [15:0]   seed,
  input  logic          req,
  input  logic [BW-1:0] board_in,
  output logic [BW-1:0] board_out,
  output logic          busy,
  output logic          done,
  output logic          full
);

  state_t              r_state, w_next;
  logic [15:0]         w_lfsr;
  logic [IDX_W-1:0]    w_r, w_start, r_idx;
  logic [IDX_W:0]      r_cnt;
  logic [CELL_W-1:0]   w_val, r_val, w_cell;
  logic [BW-1:0]       r_board, r_board_out, w_board_wr;
  logic                r_full, w_zero, w_last;
  logic                w_unused_lfsr;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_ld    (seed_ld),
    .i_seed  (seed),
    .i_en    (1'b1),
    .o_state (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[7:IDX_W];
  assign w_r     = w_lfsr[IDX_W-1:0];
  assign w_start = (32'(w_r) < 32'(N)) ? w_r : IDX_W'(32'(w_r) - 32'(N));
  assign w_val   = (w_lfsr[15:8] < THRESH) ? CELL_W'(1) : CELL_W'(2);
  assign w_last  = (32'(r_cnt) == 32'(N - 1));
  assign w_zero  = (w_cell == '0);

  // Cell read and write-back both selected by a decoded compare on r_idx
  always_comb begin
    w_cell     = '0;
    w_board_wr = r_board;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(r_idx) == i) begin
        w_cell                         = r_board[i*CELL_W +: CELL_W];
        w_board_wr[i*CELL_W +: CELL_W] = r_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (req) w_next = S_SCAN;
      S_SCAN: begin
        busy = 1'b1;
        if (w_zero || w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_val       <= '0;
      r_board     <= '0;
      r_board_out <= '0;
      r_full      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_board <= board_in;
            r_idx   <= w_start;
            r_val   <= w_val;
            r_cnt   <= '0;
          end
        end
        S_SCAN: begin
          if (w_zero) begin
            r_board_out <= w_board_wr;
            r_full      <= 1'b0;
          end else if (w_last) begin
            r_board_out <= r_board;
            r_full      <= 1'b1;
          end else begin
            r_idx <= (32'(r_idx) == 32'(N - 1)) ? '0 : r_idx + 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign board_out = r_board_out;
  assign full      = r_full;

endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner: per-cycle comparison against a search
// model plus literal expectations for the key scenarios.
module tb_tile_spawner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_ld = 1'b0, seed_ld2 = 1'b0;
  logic [15:0] seed = '0, seed2 = '0;
  logic        req = 1'b0, req2 = 1'b0;
  logic [63:0] board_in = '0;
  logic [63:0] board_out;
  logic [59:0] board_in2 = '0;
  logic [59:0] board_out2;
  logic        busy, done, full, busy2, done2, full2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tile_spawner u_dut (
    .clk(clk), .rst(rst), .seed_ld(seed_ld), .seed(seed), .req(req),
    .board_in(board_in), .board_out(board_out), .busy(busy), .done(done), .full(full)
  );

  tile_spawner #(.ROWS(3), .COLS(5)) u_dut35 (
    .clk(clk), .rst(rst), .seed_ld(seed_ld2), .seed(seed2), .req(req2),
    .board_in(board_in2), .board_out(board_out2), .busy(busy2), .done(done2), .full(full2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    logic [15:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  function automatic logic [15:0] load(input logic [15:0] s);
    return (s == 16'h0) ? 16'hACE1 : s;
  endfunction

  // Outcome of one spawn on the 4x4 board, by direct circular search
  function automatic void predict(input logic [15:0] l, input logic [63:0] b,
                                  output int j_out, output logic [63:0] nb, output bit fl);
    int r, s, c;
    logic [3:0] v;
    r = int'(l[3:0]);
    s = (r < 16) ? r : r - 16;
    v = (l[15:8] < 8'd230) ? 4'd1 : 4'd2;
    fl = 1'b1; nb = b; j_out = 15;
    for (int j = 0; j < 16; j++) begin
      c = (s + j) % 16;
      if (b[c*4 +: 4] == 4'h0) begin
        nb[c*4 +: 4] = v;
        j_out = j;
        fl = 1'b0;
        break;
      end
    end
  endfunction

  // Model for the 4x4 instance
  int          cyc = 0, req_cyc = 0, done_at = -1;
  bit          pend = 0, m_valid = 0, m_full = 0, exp_full = 0;
  logic [63:0] m_bout = '0, exp_board = '0;
  logic [15:0] m_lfsr = 16'hACE1;

  always @(posedge clk) begin
    int jj;
    if (rst) begin
      pend = 0; m_bout = '0; m_full = 0; m_lfsr = 16'hACE1; m_valid = 1;
    end else begin
      if (pend && cyc == done_at) pend = 0;
      else if (!pend && req) begin
        predict(m_lfsr, board_in, jj, exp_board, exp_full);
        done_at = cyc + 2 + jj;
        req_cyc = cyc;
        pend = 1;
      end
      m_lfsr = seed_ld ? load(seed) : step(m_lfsr);
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit e_done, e_busy;
    if (m_valid) begin
      e_done = pend && cyc == done_at;
      e_busy = pend && cyc > req_cyc && cyc < done_at;
      if (e_done) begin
        m_bout = exp_board;
        m_full = exp_full;
      end
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("full", 64'(full), 64'(m_full));
      chk("board_out", board_out, m_bout);
    end
  end

  // LFSR model for the 3x5 instance; snapshot taken when its request is sampled
  logic [15:0] m_lfsr2 = 16'hACE1, snap2 = '0;
  always @(posedge clk) begin
    if (rst) m_lfsr2 = 16'hACE1;
    else begin
      if (req2) snap2 = m_lfsr2;
      m_lfsr2 = seed_ld2 ? load(seed2) : step(m_lfsr2);
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic do_req();
    req = 1'b1; nxt(); req = 1'b0;
  endtask

  task automatic do_req2();
    req2 = 1'b1; nxt(); req2 = 1'b0;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_ld = 1'b1; seed = s; nxt(); seed_ld = 1'b0;
  endtask

  task automatic wait_done(input bit second, input int maxc, output int lat);
    lat = maxc + 1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if ((second ? done2 : done) === 1'b1) begin
        lat = k;
        break;
      end
      nxt();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, ndone, nz, ones, idx;
    logic [3:0]  v;
    logic [59:0] e2;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_board", board_out, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    rst = 1'b0;
    nxt();

    // Empty board, seed 1: start 1, value 1, done two cycles after req
    board_in = '0;
    load_seed(16'h0001);
    do_req();
    wait_done(0, 40, lat);
    chk("empty_lat", 64'(lat), 64'd2);
    chk("empty_board", board_out, 64'h0000_0000_0000_0010);
    chk("empty_full", 64'(full), 64'h0);
    nxt();

    // Only cell 5 empty, start 6: wraps through all 16 cells
    board_in = 64'h3333_3333_3303_3333;
    load_seed(16'h0006);
    do_req();
    wait_done(0, 40, lat);
    chk("wrap_lat", 64'(lat), 64'd17);
    chk("wrap_board", board_out, 64'h3333_3333_3313_3333);
    chk("wrap_full", 64'(full), 64'h0);
    nxt();

    // Full board
    board_in = {16{4'h3}};
    do_req();
    wait_done(0, 40, lat);
    chk("full_lat", 64'(lat), 64'd17);
    chk("full_flag", 64'(full), 64'h1);
    chk("full_board", board_out, {16{4'h3}});
    repeat (3) nxt();
    chk("full_hold", 64'(full), 64'h1);

    // Repeated req during SCAN and board_in change after capture are ignored
    board_in = 64'h0000_0000_3333_3000;
    load_seed(16'h0003);
    do_req();
    board_in = '1;
    nxt(); req = 1'b1;
    nxt(); req = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) ndone++;
      nxt();
    end
    chk("ignore_req_dones", 64'(ndone), 64'd1);
    chk("ignore_req_board", board_out, 64'h0000_0001_3333_3000);

    // Reset in second SCAN cycle abandons the spawn
    board_in = {16{4'h3}};
    load_seed(16'h0005);
    do_req();
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
      nxt();
    end
    chk("rst_scan_dones", 64'(ndone), 64'd0);
    chk("rst_scan_board", board_out, 64'h0);
    board_in = '0;
    do_req();
    wait_done(0, 40, lat);
    chk("post_rst_lat", 64'(lat), 64'd2);
    nz = 0;
    for (int c = 0; c < 16; c++) begin
      v = board_out[c*4 +: 4];
      if (v != 4'h0) begin
        nz++;
        if (v != 4'd1 && v != 4'd2) nz += 100;
      end
    end
    chk("post_rst_one_cell", 64'(nz), 64'd1);
    nxt();

    // 3x5 board: zero seed selects the default, giving start 1 and value 1
    seed_ld2 = 1'b1; seed2 = 16'h0000; nxt(); seed_ld2 = 1'b0;
    do_req2();
    wait_done(1, 40, lat);
    chk("b35_first_lat", 64'(lat), 64'd2);
    chk("b35_first_board", 64'(board_out2), 64'h10);
    nxt();

    ones = 0;
    for (int n = 0; n < 1000; n++) begin
      do_req2();
      wait_done(1, 40, lat);
      chk("b35_lat", 64'(lat), 64'd2);
      idx = int'(snap2[3:0]);
      if (idx >= 15) idx -= 15;
      v = (snap2[15:8] < 8'd230) ? 4'd1 : 4'd2;
      if (v == 4'd1) ones++;
      e2 = 60'(v) << (idx * 4);
      chk("b35_board", 64'(board_out2), 64'(e2));
      nxt();
    end
    chk("b35_ones_in_range", 64'((ones >= 800 && ones <= 980) ? 1 : 0), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
